seq_shifter: RTL

- Multi-cycle, parametrised shifter for the datapath. Supports logical shift left, logical shift right, arithmetic shift right and rotate right.
- Processes STEP bit positions per clock. Produces a carry-out and a zero flag. Uses valid/ready handshakes on input and output.
- Sits between operand fetch and ALU writeback, where a full single-cycle barrel shifter is too costly in area or timing.

---
 rtl/shifter_pkg.sv | 17 +
 rtl/shift_step.sv | 52 +++++
 rtl/seq_shifter.sv | 104 ++++++++++
 3 files changed

// File: rtl/shifter_pkg.sv
// Shared encodings for the multi-cycle shifter: operation codes and FSM states.
package shifter_pkg;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } sh_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } sh_state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational chunk shifter: applies i_k (0..STEP) single-bit operations.
// Carry is the last bit shifted out; i_carry passes through when i_k == 0.
module shift_step
  import shifter_pkg::*;
#(
  parameter int W    = 32,
  parameter int STEP = 1,
  parameter int KW   = $clog2(STEP + 1)
) (
  input  logic [W-1:0]  i_data,
  input  sh_op_e        i_op,
  input  logic [KW-1:0] i_k,
  input  logic          i_carry,
  output logic [W-1:0]  o_data,
  output logic          o_carry
);

  logic [W-1:0] w_d;
  logic         w_c;

  // Unrolled chain of STEP single-bit stages, each gated by i_k.
  always_comb begin
    w_d = i_data;
    w_c = i_carry;
    for (int i = 0; i < STEP; i++) begin
      if (KW'(i) < i_k) begin
        unique case (i_op)
          SH_LSL: begin
            w_c = w_d[W-1];
            w_d = {w_d[W-2:0], 1'b0};
          end
          SH_LSR: begin
            w_c = w_d[0];
            w_d = {1'b0, w_d[W-1:1]};
          end
          SH_ASR: begin
            w_c = w_d[0];
            w_d = {w_d[W-1], w_d[W-1:1]};
          end
          SH_ROR: begin
            w_c = w_d[0];
            w_d = {w_d[0], w_d[W-1:1]};
          end
        endcase
      end
    end
  end

  assign o_data  = w_d;
  assign o_carry = w_c;

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter (LSL/LSR/ASR/ROR), STEP bits per clock, valid/ready on both
// sides. The working data/carry registers double as the result registers.
module seq_shifter
  import shifter_pkg::*;
#(
  parameter int W    = 32,
  parameter int SW   = 5,
  parameter int STEP = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic [SW-1:0] in_shamt,
  input  logic [1:0]    in_op,
  input  logic          in_carry,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic          out_carry,
  output logic          out_zero
);

  localparam int KW = $clog2(STEP + 1);

  sh_state_e     r_state, w_state_nxt;
  sh_op_e        r_op, w_op_nxt;
  logic [SW-1:0] r_count, w_count_nxt;
  logic [W-1:0]  r_data, w_data_nxt;
  logic          r_carry, w_carry_nxt;

  logic [31:0]   w_cnt32;
  logic [KW-1:0] w_k;
  logic [SW-1:0] w_count_dec;
  logic [W-1:0]  w_step_data;
  logic          w_step_carry;

  // k = min(count, STEP); compared at 32 bits so STEP may exceed 2^SW-1.
  assign w_cnt32     = 32'(r_count);
  assign w_k         = (w_cnt32 >= 32'(STEP)) ? KW'(STEP) : KW'(r_count);
  assign w_count_dec = r_count - SW'(w_k);

  shift_step #(.W(W), .STEP(STEP), .KW(KW)) u_step (
    .i_data  (r_data),
    .i_op    (r_op),
    .i_k     (w_k),
    .i_carry (r_carry),
    .o_data  (w_step_data),
    .o_carry (w_step_carry)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_op    <= SH_LSL;
      r_count <= '0;
      r_data  <= '0;
      r_carry <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_op    <= w_op_nxt;
      r_count <= w_count_nxt;
      r_data  <= w_data_nxt;
      r_carry <= w_carry_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_count_nxt = r_count;
    w_data_nxt  = r_data;
    w_carry_nxt = r_carry;
    unique case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_op_nxt    = sh_op_e'(in_op);
          w_count_nxt = in_shamt;
          w_data_nxt  = in_data;
          w_carry_nxt = in_carry;
          w_state_nxt = (in_shamt == '0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        w_data_nxt  = w_step_data;
        w_carry_nxt = w_step_carry;
        w_count_nxt = w_count_dec;
        if (w_count_dec == '0) w_state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign out_data  = r_data;
  assign out_carry = r_carry;
  assign out_zero  = (r_data == '0);

endmodule
